vx_local_mem_dma: RTL and testbench
===================================

Name: VX_local_mem_dma

Overview:
- Requester-side engine for the local-memory word bus. It turns one block command into a stream of word requests.
- Two operations: copy `count` words from a source address to a destination address, or fill `count` destination words with a constant.
- Sits beside a core's local-memory port as an extra bus master (one requester slot). It issues reads and writes, consumes read responses and signals completion.
- Tracks outstanding reads with a small reorder buffer, because bank responses may return out of order.

Parameters:
- ADDR_WIDTH, 14, word-address width of the local-memory port.
- WORD_SIZE, 4, bytes per word; WORD_WIDTH = WORD_SIZE*8.
- TAG_WIDTH, 16, width of the bus request/response tag; must be >= SLOT_BITS.
- MAX_PENDING, 4, outstanding reads / reorder slots; power of 2, >= 2. SLOT_BITS = CLOG2(MAX_PENDING).
- COUNT_WIDTH, 16, width of the word-count field.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_op  in  1  0 = COPY, 1 = FILL.
- cmd_src  in  ADDR_WIDTH  source word address (ignored for FILL).
- cmd_dst  in  ADDR_WIDTH  destination word address.
- cmd_count  in  COUNT_WIDTH  number of words.
- cmd_fill  in  WORD_WIDTH  fill value.
- cmd_ready  out  1  engine idle; command accepted on valid&&ready.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- mem_req_valid  out  1  request valid.
- mem_req_rw  out  1  1 = write.
- mem_req_addr  out  ADDR_WIDTH  word address.
- mem_req_byteen  out  WORD_SIZE  byte enables.
- mem_req_data  out  WORD_WIDTH  write data.
- mem_req_tag  out  TAG_WIDTH  request tag.
- mem_req_ready  in  1  request accepted.
- mem_rsp_valid  in  1  read response valid.
- mem_rsp_data  in  WORD_WIDTH  read data.
- mem_rsp_tag  in  TAG_WIDTH  response tag.
- mem_rsp_ready  out  1  always 1.

Behaviour:
- **Reset** (reset==0 at a clk edge):
  - State goes to IDLE, all slots freed, all counters cleared.
  - Outputs: cmd_ready=1, busy=0, done=0, mem_req_valid=0; other mem_req_* fields 0.
  - mem_rsp_ready=1 in every cycle, including during reset.
- **IDLE**:
  - cmd_ready=1.
  - On cmd_valid at edge T: latch the command, clear counters rd_issued, wr_issued, rd_ptr, wr_ptr.
  - count != 0: go to RUN at T+1. count == 0: stay IDLE and pulse done at T+1.
- **RUN**:
  - busy=1, cmd_ready=0.
  - One request presented per cycle; fields change only after the mem_req_ready handshake, and mem_req_valid is never withdrawn before it.
- **Write candidate** (priority):
  - FILL: write candidate whenever wr_issued < count; data = fill value.
  - COPY: write candidate when slot[wr_ptr] is filled; data = slot data.
  - Write fields: addr = dst + wr_issued (mod 2^ADDR_WIDTH), byteen all ones, tag = 0.
- **Read candidate** (COPY only, used when no write candidate):
  - Condition: rd_issued < count and slot[rd_ptr] free.
  - Fields: addr = src + rd_issued (mod 2^ADDR_WIDTH), tag = zero-extended rd_ptr.
  - On handshake: slot[rd_ptr] becomes allocated, rd_ptr and rd_issued increment.
- **Read response**:
  - The low SLOT_BITS of mem_rsp_tag select the slot; data is stored and the slot becomes filled.
  - A response to a non-allocated slot is dropped (covers stale responses after reset).
  - The response may complete in the same cycle as a write handshake on a different slot.
  - A filled slot may be written out no earlier than the cycle after its response.
- **Write handshake**:
  - slot[wr_ptr] is freed, wr_ptr and wr_issued increment.
  - A freed slot can be reallocated by a read no earlier than the next cycle.
- **Completion**:
  - The handshake that makes wr_issued == count moves the state to IDLE and registers done=1 for one cycle. cmd_ready is high in that same cycle.
  - Writes have no response on this bus, so completion means "all writes accepted".
- **Widths and ordering**:
  - Counters are COUNT_WIDTH wide; pointers wrap modulo MAX_PENDING.
  - Addresses wrap silently.
  - Destination writes are always issued in ascending order.
- **Reset mid-operation**: the command is abandoned, with no done pulse. Responses that arrive later are dropped by the rule above.
- **Overlapping ranges**: a src/dst overlap is not detected. Writes read-after-write the range in order; software is responsible for overlap.

Decomposition:
- Add to VX_gpu_pkg:
  - LMEM_DMA_OP_COPY/FILL encodings.
  - lmem_dma_cmd_t struct {op, src, dst, count, fill}.
- Sub-module VX_local_mem_dma_rob holds the MAX_PENDING slots:
  - Ports: alloc, fill-by-index, head-valid/data, pop.
  - Keeps the valid/filled bits and the data RAM.
- The top level contains the FSM, the counters and the request mux.

Test Plan:
- FILL dst=0x10 count=4 value=0xCAFEBABE, req_ready=1 -> writes to 0x10..0x13 on 4 consecutive cycles starting the cycle after accept; done one cycle after the last write.
- COPY src=0x0 dst=0x40 count=8, memory responds with tags permuted (2,0,3,1) -> at most 4 reads outstanding; writes to 0x40..0x47 in order with the correct data; exactly one done pulse.
- COPY count=0 -> no mem_req_valid; done=1 the cycle after accept; cmd_ready stays 1.
- mem_req_ready toggled 0/1 randomly -> request fields stable while valid&&!ready; no duplicate or skipped addresses.
- dst=2^ADDR_WIDTH-2, FILL count=4 -> write addresses ..FE, ..FF, 0x0, 0x1.
- reset=0 mid-COPY with 3 reads pending, then responses arrive after release -> responses dropped; no mem requests and no done; next command executes correctly.

Source files
------------

// File: rtl/vx_local_mem_dma_pkg.sv
// Shared encodings and types for the local-memory block-copy/fill engine.
package vx_local_mem_dma_pkg;

  typedef enum logic {
    LMEM_DMA_OP_COPY = 1'b0,
    LMEM_DMA_OP_FILL = 1'b1
  } lmem_dma_op_e;

  localparam int LMEM_DMA_ADDR_W  = 14;
  localparam int LMEM_DMA_WORD_W  = 32;
  localparam int LMEM_DMA_COUNT_W = 16;

  typedef struct packed {
    lmem_dma_op_e                op;
    logic [LMEM_DMA_ADDR_W-1:0]  src;
    logic [LMEM_DMA_ADDR_W-1:0]  dst;
    logic [LMEM_DMA_COUNT_W-1:0] count;
    logic [LMEM_DMA_WORD_W-1:0]  fill;
  } lmem_dma_cmd_t;

  localparam logic [0:0] LMEM_DMA_ST_IDLE = 1'b0;
  localparam logic [0:0] LMEM_DMA_ST_RUN  = 1'b1;

endpackage

// File: rtl/vx_local_mem_dma_if.sv
// Local-memory word bus: request channel from the engine, read-response channel back.
interface vx_local_mem_dma_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int WORD_SIZE  = 4,
  parameter int TAG_WIDTH  = 16
);

  logic                    mem_req_valid;
  logic                    mem_req_rw;
  logic [ADDR_WIDTH-1:0]   mem_req_addr;
  logic [WORD_SIZE-1:0]    mem_req_byteen;
  logic [WORD_SIZE*8-1:0]  mem_req_data;
  logic [TAG_WIDTH-1:0]    mem_req_tag;
  logic                    mem_req_ready;
  logic                    mem_rsp_valid;
  logic [WORD_SIZE*8-1:0]  mem_rsp_data;
  logic [TAG_WIDTH-1:0]    mem_rsp_tag;
  logic                    mem_rsp_ready;

  modport master (
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_byteen, mem_req_data, mem_req_tag,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
    output mem_rsp_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_byteen, mem_req_data, mem_req_tag,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
    input  mem_rsp_ready
  );

endinterface

// File: rtl/vx_local_mem_dma_rob.sv
// Reorder slots for outstanding reads: allocate in order, fill by tag, drain in order.
module vx_local_mem_dma_rob
  import vx_local_mem_dma_pkg::*;
#(
  parameter  int MAX_PENDING = 4,
  parameter  int WORD_WIDTH  = 32,
  localparam int SLOT_BITS   = $clog2(MAX_PENDING)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alloc_valid_i,
  input  logic [SLOT_BITS-1:0]  alloc_idx_i,
  output logic                  alloc_free_o,
  input  logic                  fill_valid_i,
  input  logic [SLOT_BITS-1:0]  fill_idx_i,
  input  logic [WORD_WIDTH-1:0] fill_data_i,
  input  logic [SLOT_BITS-1:0]  head_idx_i,
  output logic                  head_valid_o,
  output logic [WORD_WIDTH-1:0] head_data_o,
  input  logic                  pop_i
);

  logic [MAX_PENDING-1:0] valid_q, valid_d;
  logic [MAX_PENDING-1:0] filled_q, filled_d;
  logic [WORD_WIDTH-1:0]  data_q [MAX_PENDING];
  logic                   fill_hit;

  // Responses for slots that are not allocated (e.g. stale after reset) are dropped.
  assign fill_hit = fill_valid_i && valid_q[fill_idx_i];

  always_comb begin
    valid_d  = valid_q;
    filled_d = filled_q;
    if (fill_hit) begin
      filled_d[fill_idx_i] = 1'b1;
    end
    if (pop_i) begin
      valid_d[head_idx_i]  = 1'b0;
      filled_d[head_idx_i] = 1'b0;
    end
    if (alloc_valid_i) begin
      valid_d[alloc_idx_i]  = 1'b1;
      filled_d[alloc_idx_i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q  <= '0;
      filled_q <= '0;
    end else begin
      valid_q  <= valid_d;
      filled_q <= filled_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_hit) begin
      data_q[fill_idx_i] <= fill_data_i;
    end
  end

  assign alloc_free_o = !valid_q[alloc_idx_i];
  assign head_valid_o = filled_q[head_idx_i];
  assign head_data_o  = data_q[head_idx_i];

endmodule

// File: rtl/vx_local_mem_dma.sv
// Block copy/fill engine for the local-memory word bus: one command becomes a stream
// of word reads (COPY only) and in-order word writes.
module vx_local_mem_dma
  import vx_local_mem_dma_pkg::*;
#(
  parameter  int ADDR_WIDTH  = 14,
  parameter  int WORD_SIZE   = 4,
  parameter  int TAG_WIDTH   = 16,
  parameter  int MAX_PENDING = 4,
  parameter  int COUNT_WIDTH = 16,
  localparam int WORD_WIDTH  = WORD_SIZE * 8,
  localparam int SLOT_BITS   = $clog2(MAX_PENDING)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  input  logic                   cmd_op,
  input  logic [ADDR_WIDTH-1:0]  cmd_src,
  input  logic [ADDR_WIDTH-1:0]  cmd_dst,
  input  logic [COUNT_WIDTH-1:0] cmd_count,
  input  logic [WORD_WIDTH-1:0]  cmd_fill,
  output logic                   cmd_ready,
  output logic                   busy,
  output logic                   done,
  vx_local_mem_dma_if.master     mem_if
);

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);
  localparam logic [SLOT_BITS-1:0]   SLOT_ONE = SLOT_BITS'(1);

  logic [0:0]             state_q, state_d;
  logic                   op_q;
  logic [ADDR_WIDTH-1:0]  src_q, dst_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [WORD_WIDTH-1:0]  fill_q;
  logic [COUNT_WIDTH-1:0] rd_issued_q, rd_issued_d;
  logic [COUNT_WIDTH-1:0] wr_issued_q, wr_issued_d;
  logic [SLOT_BITS-1:0]   rd_ptr_q, rd_ptr_d;
  logic [SLOT_BITS-1:0]   wr_ptr_q, wr_ptr_d;
  logic                   done_q, done_d;
  logic                   stall_rd_q, stall_rd_d;

  logic                   running, is_fill, accept;
  logic                   wr_cand, rd_cand, sel_wr;
  logic                   req_valid, req_fire, wr_fire, rd_fire;
  logic                   slot_free, head_valid;
  logic [WORD_WIDTH-1:0]  head_data;

  vx_local_mem_dma_rob #(
    .MAX_PENDING (MAX_PENDING),
    .WORD_WIDTH  (WORD_WIDTH)
  ) rob (
    .clk          (clk),
    .reset        (reset),
    .alloc_valid_i(rd_fire),
    .alloc_idx_i  (rd_ptr_q),
    .alloc_free_o (slot_free),
    .fill_valid_i (mem_if.mem_rsp_valid),
    .fill_idx_i   (mem_if.mem_rsp_tag[SLOT_BITS-1:0]),
    .fill_data_i  (mem_if.mem_rsp_data),
    .head_idx_i   (wr_ptr_q),
    .head_valid_o (head_valid),
    .head_data_o  (head_data),
    .pop_i        (wr_fire && !is_fill)
  );

  assign running = (state_q == LMEM_DMA_ST_RUN);
  assign is_fill = (op_q == LMEM_DMA_OP_FILL);
  assign accept  = (state_q == LMEM_DMA_ST_IDLE) && cmd_valid;

  // A read left waiting on ready keeps the bus even if a write becomes eligible,
  // so presented fields never change before the handshake.
  always_comb begin
    wr_cand   = is_fill ? (wr_issued_q < count_q) : head_valid;
    rd_cand   = !is_fill && (rd_issued_q < count_q) && slot_free;
    sel_wr    = wr_cand && !stall_rd_q;
    req_valid = running && (sel_wr || rd_cand);
    req_fire  = req_valid && mem_if.mem_req_ready;
    wr_fire   = req_fire && sel_wr;
    rd_fire   = req_fire && !sel_wr;
  end

  always_comb begin
    mem_if.mem_req_valid  = req_valid;
    mem_if.mem_req_rw     = 1'b0;
    mem_if.mem_req_addr   = '0;
    mem_if.mem_req_byteen = '0;
    mem_if.mem_req_data   = '0;
    mem_if.mem_req_tag    = '0;
    if (req_valid) begin
      mem_if.mem_req_byteen = '1;
      if (sel_wr) begin
        mem_if.mem_req_rw   = 1'b1;
        mem_if.mem_req_addr = dst_q + ADDR_WIDTH'(wr_issued_q);
        mem_if.mem_req_data = is_fill ? fill_q : head_data;
      end else begin
        mem_if.mem_req_addr = src_q + ADDR_WIDTH'(rd_issued_q);
        mem_if.mem_req_tag  = TAG_WIDTH'(rd_ptr_q);
      end
    end
  end

  assign mem_if.mem_rsp_ready = 1'b1;

  always_comb begin
    state_d     = state_q;
    rd_issued_d = rd_issued_q;
    wr_issued_d = wr_issued_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    done_d      = 1'b0;
    stall_rd_d  = req_valid && !sel_wr && !mem_if.mem_req_ready;
    if (accept) begin
      rd_issued_d = '0;
      wr_issued_d = '0;
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      if (cmd_count != '0) begin
        state_d = LMEM_DMA_ST_RUN;
      end else begin
        done_d = 1'b1;
      end
    end
    if (rd_fire) begin
      rd_issued_d = rd_issued_q + CNT_ONE;
      rd_ptr_d    = rd_ptr_q + SLOT_ONE;
    end
    if (wr_fire) begin
      wr_issued_d = wr_issued_q + CNT_ONE;
      wr_ptr_d    = wr_ptr_q + SLOT_ONE;
      if (wr_issued_q + CNT_ONE == count_q) begin
        state_d = LMEM_DMA_ST_IDLE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= LMEM_DMA_ST_IDLE;
      rd_issued_q <= '0;
      wr_issued_q <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      done_q      <= 1'b0;
      stall_rd_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_issued_q <= rd_issued_d;
      wr_issued_q <= wr_issued_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      done_q      <= done_d;
      stall_rd_q  <= stall_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q    <= LMEM_DMA_OP_COPY;
      src_q   <= '0;
      dst_q   <= '0;
      count_q <= '0;
      fill_q  <= '0;
    end else if (accept) begin
      op_q    <= cmd_op;
      src_q   <= cmd_src;
      dst_q   <= cmd_dst;
      count_q <= cmd_count;
      fill_q  <= cmd_fill;
    end
  end

  assign cmd_ready = (state_q == LMEM_DMA_ST_IDLE);
  assign busy      = running;
  assign done      = done_q;

endmodule

// File: tb/tb_vx_local_mem_dma.sv
// Scoreboard bench for vx_local_mem_dma: expected writes/reads queued at issue,
// a negedge monitor checks every bus handshake and done pulse.
module tb_vx_local_mem_dma;

  localparam int AW = 14;
  localparam int WS = 4;
  localparam int TW = 16;
  localparam int NP = 4;
  localparam int CW = 16;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  typedef struct {
    logic [AW-1:0] addr;
    int unsigned   tag;
  } rd_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_op = 1'b0;
  logic [AW-1:0] cmd_src = '0;
  logic [AW-1:0] cmd_dst = '0;
  logic [CW-1:0] cmd_count = '0;
  logic [31:0]   cmd_fill = '0;
  logic          cmd_ready, busy, done;

  int  n_tests = 0;
  int  n_fail = 0;
  wr_t wr_exp[$];
  rd_t rd_exp[$];
  rd_t pend[$];
  rd_t batch[$];
  int  done_exp = 0;
  int  rdy_mode = 0;
  bit  rsp_hold = 1'b0;
  int  rd_cnt = 0;
  int  wr_cnt = 0;

  always #5 clk = ~clk;

  vx_local_mem_dma_if #(.ADDR_WIDTH(AW), .WORD_SIZE(WS), .TAG_WIDTH(TW)) mem_if ();

  vx_local_mem_dma #(
    .ADDR_WIDTH (AW),
    .WORD_SIZE  (WS),
    .TAG_WIDTH  (TW),
    .MAX_PENDING(NP),
    .COUNT_WIDTH(CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_op   (cmd_op),
    .cmd_src  (cmd_src),
    .cmd_dst  (cmd_dst),
    .cmd_count(cmd_count),
    .cmd_fill (cmd_fill),
    .cmd_ready(cmd_ready),
    .busy     (busy),
    .done     (done),
    .mem_if   (mem_if)
  );

  function automatic logic [31:0] mw(input logic [AW-1:0] a);
    return {2'b10, a, 2'b01, ~a};
  endfunction

  function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  // Memory side: ready pattern and read responses, reordered (2,0,3,1) per batch.
  always @(posedge clk) begin
    rd_t r;
    rd_t items[$];
    #1;
    case (rdy_mode)
      0:       mem_if.mem_req_ready = 1'b1;
      1:       mem_if.mem_req_ready = ($urandom_range(0, 1) != 0);
      default: mem_if.mem_req_ready = 1'b0;
    endcase
    mem_if.mem_rsp_valid = 1'b0;
    mem_if.mem_rsp_tag   = '0;
    mem_if.mem_rsp_data  = '0;
    if (!rsp_hold) begin
      if (batch.size() != 0) begin
        r = batch.pop_front();
        mem_if.mem_rsp_valid = 1'b1;
        mem_if.mem_rsp_tag   = TW'(r.tag);
        mem_if.mem_rsp_data  = mw(r.addr);
      end else if (pend.size() >= NP || (pend.size() != 0 && rd_exp.size() == 0)) begin
        items = pend;
        pend.delete();
        if (items.size() > 2) batch.push_back(items[2]);
        if (items.size() > 0) batch.push_back(items[0]);
        if (items.size() > 3) batch.push_back(items[3]);
        if (items.size() > 1) batch.push_back(items[1]);
      end
    end
  end

  // Monitor: compares every handshake and done pulse against the scoreboard queues.
  logic       prev_stall = 1'b0;
  logic [66:0] prev_fields = '0;
  always @(negedge clk) begin
    wr_t e;
    rd_t q;
    logic [66:0] cur;
    cur = {mem_if.mem_req_rw, mem_if.mem_req_addr, mem_if.mem_req_data, mem_if.mem_req_tag, mem_if.mem_req_byteen};
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", mem_if.mem_req_valid, 1);
        check("stall_fields_stable", cur, prev_fields);
      end
      if (mem_if.mem_req_valid && mem_if.mem_req_ready) begin
        if (mem_if.mem_req_rw) begin
          if (wr_exp.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL spurious_write: got addr %0h expected no write", mem_if.mem_req_addr);
          end else begin
            e = wr_exp.pop_front();
            check("write_addr", mem_if.mem_req_addr, e.addr);
            check("write_data", mem_if.mem_req_data, e.data);
            check("write_byteen", mem_if.mem_req_byteen, 4'hF);
            check("write_tag", mem_if.mem_req_tag, 0);
            wr_cnt++;
          end
        end else begin
          if (rd_exp.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL spurious_read: got addr %0h expected no read", mem_if.mem_req_addr);
          end else begin
            q = rd_exp.pop_front();
            check("read_addr", mem_if.mem_req_addr, q.addr);
            check("read_tag", mem_if.mem_req_tag, q.tag);
            check("outstanding_below_max", (rd_cnt - wr_cnt) < NP, 1);
            rd_cnt++;
            pend.push_back(q);
          end
        end
      end
      prev_stall  = mem_if.mem_req_valid && !mem_if.mem_req_ready;
      prev_fields = cur;
      if (done) begin
        n_tests++;
        if (done_exp == 0) begin
          n_fail++;
          $display("FAIL spurious_done: got done=1 expected 0");
        end else begin
          done_exp--;
        end
      end
    end
  end

  task automatic issue(input logic op, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                       input int unsigned cnt, input logic [31:0] fv);
    logic [AW-1:0] a;
    check("cmd_ready_at_issue", cmd_ready, 1);
    rd_cnt = 0;
    wr_cnt = 0;
    for (int unsigned i = 0; i < cnt; i++) begin
      a = dst + AW'(i);
      wr_exp.push_back('{addr: a, data: (op ? fv : mw(src + AW'(i)))});
      if (!op) rd_exp.push_back('{addr: src + AW'(i), tag: i % NP});
    end
    done_exp++;
    cmd_op    = op;
    cmd_src   = src;
    cmd_dst   = dst;
    cmd_count = CW'(cnt);
    cmd_fill  = fv;
    cmd_valid = 1'b1;
    @(negedge clk); #2;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (!(wr_exp.size() == 0 && done_exp == 0 && cmd_ready === 1'b1) && k < budget) begin
      @(negedge clk); #2;
      k++;
    end
    check("idle_within_budget", k < budget, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_req_valid"}, mem_if.mem_req_valid, 0);
    check({tag, "_req_fields"}, {mem_if.mem_req_rw, mem_if.mem_req_addr, mem_if.mem_req_data,
                                 mem_if.mem_req_tag, mem_if.mem_req_byteen}, 0);
    check({tag, "_rsp_ready"}, mem_if.mem_rsp_ready, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    #2 reset = 1'b1;
    @(negedge clk); #2;

    // FILL with exact cycle timing
    issue(1'b1, 14'h0010, 14'h0010, 4, 32'hCAFEBABE);
    check("fill_busy", busy, 1);
    check("fill_cmd_ready_low", cmd_ready, 0);
    for (int i = 0; i < 4; i++) begin
      check("fill_cycle_valid", mem_if.mem_req_valid, 1);
      check("fill_cycle_rw", mem_if.mem_req_rw, 1);
      check("fill_cycle_addr", mem_if.mem_req_addr, 14'h0010 + 14'(i));
      @(negedge clk); #2;
    end
    check("fill_done_pulse", done, 1);
    check("fill_done_cmd_ready", cmd_ready, 1);
    check("fill_done_no_req", mem_if.mem_req_valid, 0);
    @(negedge clk); #2;
    check("fill_done_one_cycle", done, 0);
    wait_idle(50);

    // COPY 8 words with permuted responses
    issue(1'b0, 14'h0000, 14'h0040, 8, 32'h0);
    wait_idle(200);

    // COPY count 0
    issue(1'b0, 14'h0123, 14'h0456, 0, 32'h0);
    check("zero_done", done, 1);
    check("zero_cmd_ready", cmd_ready, 1);
    check("zero_no_req", mem_if.mem_req_valid, 0);
    check("zero_not_busy", busy, 0);
    @(negedge clk); #2;
    check("zero_done_one_cycle", done, 0);
    wait_idle(10);

    // Address wrap at top of the space
    issue(1'b1, 14'h0000, 14'h3FFE, 4, 32'h0BADF00D);
    wait_idle(50);

    // Random backpressure
    rdy_mode = 1;
    issue(1'b1, 14'h0000, 14'h0500, 6, 32'h12345678);
    wait_idle(300);
    issue(1'b0, 14'h0300, 14'h0310, 10, 32'h0);
    wait_idle(600);
    issue(1'b0, 14'h3FFD, 14'h0700, 5, 32'h0);
    wait_idle(400);
    rdy_mode = 0;

    // Reset with three reads outstanding; their late responses must be ignored
    rsp_hold = 1'b1;
    issue(1'b0, 14'h0020, 14'h0080, 8, 32'h0);
    k = 0;
    while (rd_cnt < 3 && k < 50) begin
      @(negedge clk); #2;
      k++;
    end
    rdy_mode = 2;
    check("abort_three_reads", rd_cnt, 3);
    @(negedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("midreset");
    #2;
    @(negedge clk); #2;
    reset = 1'b1;
    wr_exp.delete();
    rd_exp.delete();
    done_exp = 0;
    check("abort_stale_pending", pend.size(), 3);
    rdy_mode = 0;
    rsp_hold = 1'b0;
    repeat (12) begin
      @(negedge clk); #2;
    end
    check("abort_stale_delivered", pend.size() + batch.size(), 0);
    check("abort_idle", busy, 0);
    check("abort_cmd_ready", cmd_ready, 1);

    // Next command after abort runs cleanly
    rdy_mode = 1;
    issue(1'b0, 14'h0100, 14'h0200, 5, 32'h0);
    wait_idle(400);
    rdy_mode = 0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
